// File: rtl/seq_stim_ctrl_if.sv
// Control-side bundle of the stimulus sequencer: run request, pattern setup
// and run status/results.
interface seq_stim_ctrl_if #(
  parameter int PAT_W = 16
);
  logic             start;
  logic             abort;
  logic [PAT_W-1:0] pattern;
  logic [4:0]       len;
  logic             busy;
  logic             done;
  logic [4:0]       hit_cnt;
  logic [PAT_W-1:0] hit_map;

  modport master (
    output start, abort, pattern, len,
    input  busy, done, hit_cnt, hit_map
  );

  modport slave (
    input  start, abort, pattern, len,
    output busy, done, hit_cnt, hit_map
  );
endinterface

// File: rtl/seq_stim_ctrl.sv
// Serial stimulus sequencer: shifts a latched pattern LSB first into a stepped
// sequence detector and records which bits produced a detection.
module seq_stim_ctrl #(
  parameter int TICK_DIV = 12_500_000,
  parameter int PAT_W    = 16
) (
  input  logic          clk,
  input  logic          reset,
  seq_stim_ctrl_if.slave ctrl,
  input  logic          det_hit,
  output logic          det_in,
  output logic          det_step,
  output logic          det_rst
);

  localparam int          IDX_W     = (PAT_W > 1) ? $clog2(PAT_W) : 1;
  localparam logic [4:0]  PAT_W5    = 5'(PAT_W);
  localparam logic [27:0] TICK_LAST = 28'(TICK_DIV - 1);

  typedef enum logic [2:0] {
    ST_IDLE   = 3'd0,
    ST_CLEAR  = 3'd1,
    ST_WAIT   = 3'd2,
    ST_STEP   = 3'd3,
    ST_FINISH = 3'd4
  } state_t;

  state_t           state_r, state_nxt_s;
  logic [IDX_W-1:0] idx_r, idx_nxt_s;
  logic [27:0]      presc_r, presc_nxt_s;
  logic [PAT_W-1:0] pattern_r, pattern_nxt_s;
  logic [4:0]       len_r, len_nxt_s;
  logic [4:0]       hit_cnt_r, hit_cnt_nxt_s;
  logic [PAT_W-1:0] hit_map_r, hit_map_nxt_s;
  logic             abort_r, abort_nxt_s;
  logic             det_in_s, det_step_s, det_rst_s, busy_s, done_s;

  // State and datapath registers; reset wins over every input.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_r   <= ST_IDLE;
      idx_r     <= '0;
      presc_r   <= 28'd0;
      pattern_r <= '0;
      len_r     <= 5'd0;
      hit_cnt_r <= 5'd0;
      hit_map_r <= '0;
      abort_r   <= 1'b0;
    end else begin
      state_r   <= state_nxt_s;
      idx_r     <= idx_nxt_s;
      presc_r   <= presc_nxt_s;
      pattern_r <= pattern_nxt_s;
      len_r     <= len_nxt_s;
      hit_cnt_r <= hit_cnt_nxt_s;
      hit_map_r <= hit_map_nxt_s;
      abort_r   <= abort_nxt_s;
    end
  end

  // Next-state logic and state-decoded detector/status outputs.
  always_comb begin
    state_nxt_s   = state_r;
    idx_nxt_s     = idx_r;
    presc_nxt_s   = presc_r;
    pattern_nxt_s = pattern_r;
    len_nxt_s     = len_r;
    hit_cnt_nxt_s = hit_cnt_r;
    hit_map_nxt_s = hit_map_r;
    abort_nxt_s   = 1'b0;
    det_in_s      = 1'b0;
    det_step_s    = 1'b0;
    busy_s        = 1'b1;
    done_s        = 1'b0;

    case (state_r)
      ST_IDLE: begin
        busy_s = 1'b0;
        if (ctrl.start) begin
          pattern_nxt_s = ctrl.pattern;
          len_nxt_s     = (ctrl.len > PAT_W5) ? PAT_W5 : ctrl.len;
          idx_nxt_s     = '0;
          presc_nxt_s   = 28'd0;
          hit_cnt_nxt_s = 5'd0;
          hit_map_nxt_s = '0;
          state_nxt_s   = ST_CLEAR;
        end else begin
          state_nxt_s = ST_IDLE;
        end
      end
      ST_CLEAR: begin
        presc_nxt_s = 28'd0;
        if (ctrl.abort) begin
          abort_nxt_s = 1'b1;
          state_nxt_s = ST_IDLE;
        end else if (len_r == 5'd0) begin
          state_nxt_s = ST_FINISH;
        end else begin
          state_nxt_s = ST_WAIT;
        end
      end
      ST_WAIT: begin
        det_in_s = pattern_r[idx_r];
        if (ctrl.abort) begin
          abort_nxt_s = 1'b1;
          presc_nxt_s = 28'd0;
          state_nxt_s = ST_IDLE;
        end else if (presc_r == TICK_LAST) begin
          presc_nxt_s = 28'd0;
          state_nxt_s = ST_STEP;
        end else begin
          presc_nxt_s = presc_r + 28'd1;
        end
      end
      ST_STEP: begin
        det_in_s   = pattern_r[idx_r];
        det_step_s = 1'b1;
        // A hit in the step cycle is recorded even if the run is being aborted.
        if (det_hit) begin
          hit_cnt_nxt_s        = (hit_cnt_r == 5'd31) ? 5'd31 : hit_cnt_r + 5'd1;
          hit_map_nxt_s[idx_r] = 1'b1;
        end else begin
          hit_cnt_nxt_s = hit_cnt_r;
        end
        if (ctrl.abort) begin
          abort_nxt_s = 1'b1;
          state_nxt_s = ST_IDLE;
        end else if (5'(idx_r) == len_r - 5'd1) begin
          state_nxt_s = ST_FINISH;
        end else begin
          idx_nxt_s   = idx_r + IDX_W'(1);
          state_nxt_s = ST_WAIT;
        end
      end
      ST_FINISH: begin
        done_s      = 1'b1;
        state_nxt_s = ST_IDLE;
      end
      default: begin
        busy_s      = 1'b0;
        state_nxt_s = ST_IDLE;
      end
    endcase

    // Detector clear covers the clear state, the cycle after an abort and reset.
    det_rst_s = reset || (state_r == ST_CLEAR) || abort_r;
  end

  assign det_in       = det_in_s   & ~reset;
  assign det_step     = det_step_s & ~reset;
  assign det_rst      = det_rst_s;
  assign ctrl.busy    = busy_s     & ~reset;
  assign ctrl.done    = done_s     & ~reset;
  assign ctrl.hit_cnt = hit_cnt_r;
  assign ctrl.hit_map = hit_map_r;

endmodule

// File: tb/tb_seq_stim_ctrl.sv
// Self-checking bench: directed and randomized runs against a "001" detector
// and a bit-level reference of the expected timing and detections.
module tb_seq_stim_ctrl;

  localparam int TICK_DIV = 4;
  localparam int PAT_W    = 16;
  localparam int P        = TICK_DIV + 1;

  logic       clk = 1'b0;
  logic       reset;
  logic       det_hit, det_in, det_step, det_rst;
  logic [1:0] det_st;
  int         n_vec = 0;
  int         n_err = 0;

  seq_stim_ctrl_if #(.PAT_W(PAT_W)) ctrl ();

  seq_stim_ctrl #(.TICK_DIV(TICK_DIV), .PAT_W(PAT_W)) dut (
    .clk      (clk),
    .reset    (reset),
    .ctrl     (ctrl),
    .det_hit  (det_hit),
    .det_in   (det_in),
    .det_step (det_step),
    .det_rst  (det_rst)
  );

  always #5 clk = ~clk;

  // "001" Mealy detector: det_st counts consecutive zeros seen (max 2).
  assign det_hit = (det_st == 2'd2) && det_in;
  always @(posedge clk) begin
    if (det_rst) det_st <= 2'd0;
    else if (det_step) det_st <= det_in ? 2'd0 : ((det_st == 2'd0) ? 2'd1 : 2'd2);
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_vec++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // One run: a_cyc = abort cycle, r_cyc = reset cycle, s_cyc = ignored start (-1 = none).
  task automatic run(input logic [15:0] pat, input int ln, input int a_cyc,
                     input int r_cyc, input int s_cyc);
    int         L, F, end_c, bi;
    logic [4:0] e_cnt;
    logic [15:0] e_map;
    logic       act, e_in;
    L = (ln > PAT_W) ? PAT_W : ln;
    F = 2 + L * P;
    end_c = (a_cyc >= 0) ? a_cyc + 1 : ((r_cyc >= 0) ? r_cyc + 1 : F);
    e_cnt = 5'd0;
    e_map = 16'h0000;
    if (r_cyc < 0) begin
      for (int k = 2; k < L; k++) begin
        if (pat[4'(k)] && !pat[4'(k - 1)] && !pat[4'(k - 2)] &&
            (a_cyc < 0 || 1 + (k + 1) * P <= a_cyc)) begin
          e_cnt = e_cnt + 5'd1;
          e_map[4'(k)] = 1'b1;
        end
      end
    end
    @(posedge clk); #1;
    reset        = 1'b0;
    ctrl.start   = 1'b1;
    ctrl.abort   = 1'b0;
    ctrl.pattern = pat;
    ctrl.len     = 5'(ln);
    for (int c = 0; c <= end_c + 1; c++) begin
      if (c > 0) begin
        @(posedge clk); #1;
        ctrl.start   = (c == s_cyc);
        ctrl.pattern = (c == s_cyc) ? ~pat : pat;
        ctrl.len     = (c == s_cyc) ? 5'd1 : 5'(ln);
        ctrl.abort   = (c == a_cyc);
        reset        = (c == r_cyc);
      end
      @(negedge clk);
      act = (c >= 1) && (c <= F) && !(r_cyc >= 0 && c >= r_cyc) && !(a_cyc >= 0 && c > a_cyc);
      e_in = 1'b0;
      if (act && c >= 2 && c <= F - 1) begin
        bi   = (c - 2) / P;
        e_in = pat[4'(bi)];
      end
      chk("busy", 32'(ctrl.busy), 32'(act));
      chk("done", 32'(ctrl.done), 32'(act && c == F));
      chk("det_step", 32'(det_step), 32'(act && c >= 1 + P && c < F && ((c - 1) % P == 0)));
      chk("det_in", 32'(det_in), 32'(e_in));
      chk("det_rst", 32'(det_rst),
          32'((c == r_cyc) || (act && c == 1) || (a_cyc >= 0 && c == a_cyc + 1)));
    end
    chk("hit_cnt", 32'(ctrl.hit_cnt), 32'(e_cnt));
    chk("hit_map", 32'(ctrl.hit_map), 32'(e_map));
  endtask

  initial begin
    int         ln, F, a, s;
    logic [15:0] pat;
    reset        = 1'b1;
    ctrl.start   = 1'b1;
    ctrl.abort   = 1'b1;
    ctrl.pattern = 16'hFFFF;
    ctrl.len     = 5'd5;
    repeat (3) @(posedge clk);
    @(negedge clk);
    chk("rst_det_rst", 32'(det_rst), 32'd1);
    chk("rst_busy", 32'(ctrl.busy), 32'd0);
    chk("rst_done", 32'(ctrl.done), 32'd0);
    chk("rst_det_step", 32'(det_step), 32'd0);
    chk("rst_det_in", 32'(det_in), 32'd0);
    chk("rst_hit_cnt", 32'(ctrl.hit_cnt), 32'd0);
    chk("rst_hit_map", 32'(ctrl.hit_map), 32'd0);

    run(16'h0004, 3, -1, -1, -1);
    run(16'h0024, 6, -1, -1, -1);
    run(16'h0008, 4, -1, -1, -1);
    run(16'h0000, 0, -1, -1, -1);
    run(16'hFFFF, 20, -1, -1, -1);
    run(16'h0004, 3, 9, -1, 8);
    run(16'h0004, 3, -1, 12, -1);
    run(16'h0004, 3, -1, -1, -1);
    run(16'h0004, 3, 16, -1, -1);
    run(16'h0024, 6, 1, -1, -1);

    for (int i = 0; i < 25; i++) begin
      pat = 16'($urandom);
      ln  = int'($urandom_range(0, 20));
      F   = 2 + ((ln > PAT_W) ? PAT_W : ln) * P;
      a   = ($urandom_range(0, 3) == 0) ? int'($urandom_range(1, F - 1)) : -1;
      s   = ($urandom_range(0, 2) == 0) ? int'($urandom_range(1, (a >= 0) ? a : F - 1)) : -1;
      run(pat, ln, a, -1, s);
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
